mfp_ahb_lite_loader_master: RTL

//  Parametrised AHB-Lite bus owner that sits between the MIPSfpga core and mfp_ahb_lite_matrix.

---
 rtl/mfp_ahb_lite_loader_master.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mfp_ahb_lite_loader_master.sv
// mfp_ahb_lite_loader_master: AHB-Lite bus owner between the MIPSfpga core and the matrix.
// Byte writes from the SREC parser are queued in a small FIFO and issued as pipelined
// single-byte AHB-Lite writes; the core is held in reset while loading and for a tail.
// Optional feature macro: MFP_LOADER_WRITE_COUNT_EN adds the loader_write_count output.
module mfp_ahb_lite_loader_master #(
   parameter int FIFO_DEPTH_LOG2   = 2,
   parameter int RESET_HOLD_CYCLES = 16
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] HADDR,
   input  logic [31:0] HWDATA,
   input  logic [2:0]  HBURST,
   input  logic [2:0]  HSIZE,
   input  logic [1:0]  HTRANS,
   input  logic [3:0]  HPROT,
   input  logic        HMASTLOCK,
   input  logic        HWRITE,
   output logic [31:0] HRDATA,
   output logic        HREADY,
   output logic        HRESP,
   output logic [31:0] S_HADDR,
   output logic [31:0] S_HWDATA,
   output logic [2:0]  S_HBURST,
   output logic [2:0]  S_HSIZE,
   output logic [1:0]  S_HTRANS,
   output logic [3:0]  S_HPROT,
   output logic        S_HMASTLOCK,
   output logic        S_HWRITE,
   input  logic [31:0] S_HRDATA,
   input  logic        S_HREADY,
   input  logic        S_HRESP,
   input  logic        loader_active,
   input  logic [31:0] write_address,
   input  logic [7:0]  write_byte,
   input  logic        write_enable,
   output logic        MFP_Reset,
   output logic        loader_overflow
`ifdef MFP_LOADER_WRITE_COUNT_EN
   ,
   output logic [15:0] loader_write_count
`endif
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int PTR_W = FIFO_DEPTH_LOG2 + 1;
   localparam int CNT_W = $clog2(RESET_HOLD_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_CPU,
      ST_HANDOVER,
      ST_LOADER,
      ST_FLUSH,
      ST_RELEASE
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        fifo_addr_q [DEPTH];
   logic [31:0]        fifo_addr_d [DEPTH];
   logic [7:0]         fifo_byte_q [DEPTH];
   logic [7:0]         fifo_byte_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic               dphase_valid_q, dphase_valid_d;
   logic [7:0]         dphase_byte_q, dphase_byte_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic               mfp_reset_q, mfp_reset_d;
   logic               overflow_q, overflow_d;
   logic               loader_active_q, loader_active_d;

   logic [FIFO_DEPTH_LOG2-1:0] wr_idx;
   logic [FIFO_DEPTH_LOG2-1:0] rd_idx;
   logic fifo_empty;
   logic fifo_full;
   logic loader_owns;
   logic issue;
   logic pop;
   logic push;
   logic loader_rise;
   logic dphase_done;

   assign wr_idx      = wr_ptr_q[FIFO_DEPTH_LOG2-1:0];
   assign rd_idx      = rd_ptr_q[FIFO_DEPTH_LOG2-1:0];
   assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
   assign fifo_full   = (wr_ptr_q[FIFO_DEPTH_LOG2] != rd_ptr_q[FIFO_DEPTH_LOG2]) && (wr_idx == rd_idx);
   assign loader_owns = (state_q == ST_LOADER) || (state_q == ST_FLUSH);
   assign issue       = loader_owns && !fifo_empty;
   assign pop         = issue && S_HREADY;
   assign push        = write_enable && (!fifo_full || pop);
   assign loader_rise = loader_active && !loader_active_q;
   assign dphase_done = dphase_valid_q && S_HREADY;

   assign MFP_Reset       = mfp_reset_q;
   assign loader_overflow = overflow_q;

   // FIFO pointers/storage, loader data-phase tracking and the sticky overflow flag
   always_comb begin
      fifo_addr_d     = fifo_addr_q;
      fifo_byte_d     = fifo_byte_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      dphase_valid_d  = dphase_valid_q;
      dphase_byte_d   = dphase_byte_q;
      overflow_d      = overflow_q;
      loader_active_d = loader_active;
      if (push) begin
         fifo_addr_d[wr_idx] = write_address;
         fifo_byte_d[wr_idx] = write_byte;
         wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (S_HREADY) begin
         dphase_valid_d = pop;
         dphase_byte_d  = fifo_byte_q[rd_idx];
      end
      if (loader_rise) begin
         overflow_d = 1'b0;
      end
      if (write_enable && fifo_full && !pop) begin
         overflow_d = 1'b1;
      end
   end

   // Bus ownership FSM plus the registered core reset request
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_CPU: begin
            if (loader_active) state_d = ST_HANDOVER;
         end
         ST_HANDOVER: begin
            if (S_HREADY) state_d = ST_LOADER;
         end
         ST_LOADER: begin
            if (!loader_active) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (loader_active) begin
               state_d = ST_LOADER;
            end else if (fifo_empty && (!dphase_valid_q || S_HREADY)) begin
               state_d    = ST_RELEASE;
               hold_cnt_d = '0;
            end
         end
         ST_RELEASE: begin
            if (loader_active) begin
               state_d = ST_LOADER;
            end else if (hold_cnt_q == CNT_W'(RESET_HOLD_CYCLES - 1)) begin
               state_d = ST_CPU;
            end else begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_CPU;
      endcase
      mfp_reset_d = (state_q != ST_CPU) && (state_d != ST_CPU);
   end

   // Bus multiplexer: core passthrough, IDLE-forcing handover, or loader byte writes
   always_comb begin
      S_HADDR     = HADDR;
      S_HWDATA    = HWDATA;
      S_HBURST    = HBURST;
      S_HSIZE     = HSIZE;
      S_HTRANS    = HTRANS;
      S_HPROT     = HPROT;
      S_HMASTLOCK = HMASTLOCK;
      S_HWRITE    = HWRITE;
      HRDATA      = S_HRDATA;
      HREADY      = S_HREADY;
      HRESP       = S_HRESP;
      case (state_q)
         ST_HANDOVER: begin
            S_HTRANS = 2'b00;
         end
         ST_LOADER, ST_FLUSH, ST_RELEASE: begin
            S_HADDR     = fifo_addr_q[rd_idx];
            S_HWDATA    = {4{dphase_byte_q}};
            S_HBURST    = 3'b000;
            S_HSIZE     = 3'b000;
            S_HTRANS    = issue ? 2'b10 : 2'b00;
            S_HPROT     = 4'b0011;
            S_HMASTLOCK = 1'b0;
            S_HWRITE    = 1'b1;
            HRDATA      = 32'h0;
            HREADY      = 1'b1;
            HRESP       = 1'b0;
         end
         default: ;
      endcase
   end

   // State registers; reset abandons any transfer and flushes the FIFO
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q         <= ST_CPU;
         fifo_addr_q     <= '{default: '0};
         fifo_byte_q     <= '{default: '0};
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         dphase_valid_q  <= 1'b0;
         dphase_byte_q   <= '0;
         hold_cnt_q      <= '0;
         mfp_reset_q     <= 1'b0;
         overflow_q      <= 1'b0;
         loader_active_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         fifo_addr_q     <= fifo_addr_d;
         fifo_byte_q     <= fifo_byte_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         dphase_valid_q  <= dphase_valid_d;
         dphase_byte_q   <= dphase_byte_d;
         hold_cnt_q      <= hold_cnt_d;
         mfp_reset_q     <= mfp_reset_d;
         overflow_q      <= overflow_d;
         loader_active_q <= loader_active_d;
      end
   end

`ifdef MFP_LOADER_WRITE_COUNT_EN
   logic [15:0] write_count_q, write_count_d;

   assign loader_write_count = write_count_q;

   // Saturating count of completed loader data phases, restarted by each new load
   always_comb begin
      write_count_d = write_count_q;
      if (loader_rise) begin
         write_count_d = 16'h0;
      end else if (dphase_done && (write_count_q != 16'hFFFF)) begin
         write_count_d = write_count_q + 16'd1;
      end
   end

   // Write counter register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         write_count_q <= 16'h0;
      end else begin
         write_count_q <= write_count_d;
      end
   end
`else
   logic unused_dphase_done;
   assign unused_dphase_done = dphase_done;
`endif

endmodule
